// File: rtl/iob_rr_arbiter_if.sv
// iob_rr_arbiter_if: bus bundle between N IOb masters, the arbiter and the shared slave
// ports: m_req/m_resp per-master request and response vectors, s_req/s_resp shared slave link
// modport slave is the arbiter's view; modport master is the environment (masters + slave) view
interface iob_rr_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;
    logic [N_MASTERS*REQ_W-1:0] m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0] s_req;
    logic [RESP_W-1:0] s_resp;
    modport slave (input m_req, output m_resp, output s_req, input s_resp);
    modport master (output m_req, input m_resp, input s_req, output s_resp);
endinterface

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: round-robin arbiter sharing one IOb slave among N_MASTERS masters
// ports: clk, rst (sync, active-high); bus (iob_rr_arbiter_if.slave) carrying m_req/m_resp/s_req/s_resp;
// grant = index of current/last granted master; busy = transaction in flight
module iob_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int G_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    iob_rr_arbiter_if.slave  bus,
    output logic [G_W-1:0]   grant,
    output logic             busy
);
    localparam int F_W = ADDR_W + DATA_W + DATA_W / 8;
    localparam int REQ_W = 1 + F_W;
    localparam int RESP_W = DATA_W + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [G_W-1:0] ptr, ptr_n, grant_n, winner, idx;
    logic [F_W-1:0] req_reg, req_n;
    logic [N_MASTERS-1:0] m_valid;
    logic [F_W-1:0] m_field [N_MASTERS];
    logic found, s_ready;
    assign s_ready = bus.s_resp[0];
    assign busy = state == BUSY;
    assign bus.s_req = {busy, req_reg};
    for (genvar k = 0; k < N_MASTERS; k++) begin : g_m
        assign m_valid[k] = bus.m_req[k*REQ_W+F_W];
        assign m_field[k] = bus.m_req[k*REQ_W +: F_W];
        assign bus.m_resp[k*RESP_W +: RESP_W] = {bus.s_resp[RESP_W-1:1], s_ready & busy & (grant == G_W'(k))};
    end
    // first valid master at or after ptr, wrapping modulo N_MASTERS
    always_comb begin
        found = 1'b0;
        winner = ptr;
        idx = ptr;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = G_W'((int'(ptr) + i) % N_MASTERS);
            if (!found && m_valid[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        grant_n = grant;
        req_n = req_reg;
        if (state == IDLE && found) begin
            state_n = BUSY;
            grant_n = winner;
            req_n = m_field[winner];
        end
        // completed master drops to lowest priority
        if (state == BUSY && s_ready) begin
            state_n = IDLE;
            ptr_n = (grant == G_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            grant <= '0;
            req_reg <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            grant <= grant_n;
            req_reg <= req_n;
        end
    end
endmodule

// File: tb/tb_iob_rr_arbiter.sv
// tb_iob_rr_arbiter: directed self-checking bench for iob_rr_arbiter with 3 masters
module tb_iob_rr_arbiter;
    localparam int N = 3;
    localparam int REQ_W = 69;
    localparam int RESP_W = 33;
    logic clk, rst;
    logic [1:0] grant;
    logic busy;
    logic mv [N];
    logic [31:0] ma [N];
    logic [31:0] mw [N];
    logic [3:0] ms [N];
    logic s_ready;
    logic [31:0] s_rdata;
    logic s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_wstrb;
    logic [N-1:0] m_ready;
    logic [31:0] m_rdata [N];
    int checks = 0;
    int failures = 0;
    iob_rr_arbiter_if #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) bus ();
    iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant(grant), .busy(busy)
    );
    always_comb begin
        for (int k = 0; k < N; k++) bus.m_req[k*REQ_W +: REQ_W] = {mv[k], ma[k], mw[k], ms[k]};
    end
    assign bus.s_resp = {s_rdata, s_ready};
    assign {s_valid, s_addr, s_wdata, s_wstrb} = bus.s_req;
    for (genvar k = 0; k < N; k++) begin : g_r
        assign m_ready[k] = bus.m_resp[k*RESP_W];
        assign m_rdata[k] = bus.m_resp[k*RESP_W+1 +: 32];
    end
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        s_ready = 1'b0;
        s_rdata = 32'hCAFE0000;
        for (int k = 0; k < N; k++) begin
            mv[k] = 1'b1;
            ma[k] = 32'h1000 + 32'(k) * 32'h10;
            mw[k] = 32'h0;
            ms[k] = 4'h0;
        end
        tick;
        tick;
        check("rst_s_valid", s_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ready", m_ready, 0);
        check("rst_rdata", m_rdata[2], 32'hCAFE0000);
        rst = 1'b0;
        tick;
        check("post_rst_busy", busy, 1);
        check("post_rst_grant", grant, 0);
        check("post_rst_addr", s_addr, 32'h1000);
        mv[1] = 1'b0;
        mv[2] = 1'b0;
        s_ready = 1'b1;
        #1;
        check("post_rst_ready", m_ready, 3'b001);
        tick;
        mv[0] = 1'b0;
        s_ready = 1'b0;
        tick;
        check("post_rst_idle", busy, 0);
        // single master read, pointer now 1
        mv[1] = 1'b1;
        ma[1] = 32'h100;
        tick;
        check("rd_c1_valid", s_valid, 1);
        check("rd_c1_grant", grant, 1);
        check("rd_c1_addr", s_addr, 32'h100);
        tick;
        check("rd_c2_valid", s_valid, 1);
        tick;
        check("rd_c3_valid", s_valid, 1);
        s_ready = 1'b1;
        s_rdata = 32'hDEADBEEF;
        #1;
        check("rd_c3_ready", m_ready, 3'b010);
        check("rd_c3_rdata", m_rdata[1], 32'hDEADBEEF);
        mv[1] = 1'b0;
        tick;
        s_ready = 1'b0;
        check("rd_c4_busy", busy, 0);
        // fairness: reset pointer to 0, then all request against a 1-cycle slave
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < N; k++) mv[k] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("rr_busy", busy, 1);
            check("rr_grant", grant, 64'(i % 3));
            s_ready = 1'b1;
            #1;
            check("rr_ready", m_ready, 64'(1 << (i % 3)));
            tick;
            s_ready = 1'b0;
            check("rr_idle", busy, 0);
            if (i == 5) for (int k = 0; k < N; k++) mv[k] = 1'b0;
        end
        // write capture, pointer back at 0
        mv[0] = 1'b1;
        ma[0] = 32'h40;
        mw[0] = 32'h12345678;
        ms[0] = 4'hF;
        tick;
        check("wr_addr", s_addr, 32'h40);
        check("wr_wstrb", s_wstrb, 4'hF);
        check("wr_wdata0", s_wdata, 32'h12345678);
        mw[0] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("wr_wdata_hold", s_wdata, 32'h12345678);
        end
        s_ready = 1'b1;
        #1;
        check("wr_ready", m_ready, 3'b001);
        mv[0] = 1'b0;
        tick;
        s_ready = 1'b0;
        // early drop by master 1, late arrival of master 0, pointer at 1
        mv[1] = 1'b1;
        ma[1] = 32'h200;
        tick;
        check("ed_grant", grant, 1);
        mv[1] = 1'b0;
        tick;
        check("ed_busy_hold", busy, 1);
        mv[0] = 1'b1;
        ma[0] = 32'h300;
        tick;
        check("ed_grant_hold", grant, 1);
        check("ed_addr_hold", s_addr, 32'h200);
        s_ready = 1'b1;
        #1;
        check("ed_ready", m_ready, 3'b010);
        tick;
        s_ready = 1'b0;
        check("ed_idle", busy, 0);
        tick;
        check("la_busy", busy, 1);
        check("la_grant", grant, 0);
        check("la_addr", s_addr, 32'h300);
        s_ready = 1'b1;
        #1;
        check("la_ready", m_ready, 3'b001);
        mv[0] = 1'b0;
        tick;
        s_ready = 1'b0;
        // reset mid-transaction, pointer at 1
        mv[2] = 1'b1;
        ma[2] = 32'h500;
        tick;
        check("mr_grant", grant, 2);
        rst = 1'b1;
        tick;
        s_ready = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_s_valid", s_valid, 0);
        check("mr_ready", m_ready, 0);
        rst = 1'b0;
        s_ready = 1'b0;
        mv[0] = 1'b1;
        ma[0] = 32'h600;
        tick;
        check("mr_restart_grant", grant, 0);
        check("mr_restart_addr", s_addr, 32'h600);
        s_ready = 1'b1;
        #1;
        check("mr_restart_ready", m_ready, 3'b001);
        mv[0] = 1'b0;
        mv[2] = 1'b0;
        tick;
        s_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
